spi_mult_master: RTL and testbench



---
 rtl/spi_mult_master_pkg.sv | 22 ++
 rtl/spi_mult_master_if.sv | 26 ++
 rtl/spi_mult_master_sclk_gen.sv | 38 +++
 rtl/spi_mult_master.sv | 106 ++++++++++
 tb/tb_spi_mult_master.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mult_master_pkg.sv
// Shared definitions for the multiplier SPI initiator: FSM states, CS polarity
// and the helper used to size the bit counter.
package spi_mult_master_pkg;

  typedef enum logic [2:0] {
    SM_IDLE = 3'd0,
    SM_SEND = 3'd1,
    SM_GAP  = 3'd2,
    SM_RECV = 3'd3,
    SM_DONE = 3'd4
  } sm_state_t;

  localparam logic CS_ACTIVE = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_mult_master_if.sv
// Host handshake plus SPI pins of the multiplier initiator. The master modport
// is the initiator's view; slave is the host/peripheral side.
interface spi_mult_master_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RES_W  = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, result, result_valid, sclk, cs, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, result, result_valid, sclk, cs, mosi
  );
endinterface

// File: rtl/spi_mult_master_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clk cycles while enabled and
// strobes rise_tick/fall_tick in the cycle before each sclk transition.
module sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap      = (cnt == CNT_W'(CLK_DIV - 1));
  assign rise_tick = en & wrap & ~sclk;
  assign fall_tick = en & wrap & sclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mult_master.sv
// SPI initiator for the multiplier peripheral: sends one operand frame, idles
// SCLK through the compute gap, then shifts the product back in.
module spi_mult_master #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RES_W      = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned WAIT_SCLKS = 16
) (
  input  logic              clk,
  input  logic              reset,
  spi_mult_master_if.master bus
);

  import spi_mult_master_pkg::*;

  localparam int unsigned BCW = $clog2(max3(DATA_W, WAIT_SCLKS, RES_W) + 1);

  sm_state_t         state_q, state_d;
  logic [BCW-1:0]    bitcnt_q;
  logic [DATA_W-1:0] tx_sh;
  logic [RES_W-1:0]  rx_sh;
  logic [RES_W-1:0]  result_q;

  logic accept;
  logic phase_done;
  logic active;
  logic sclk_w, rise_tick, fall_tick;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .en        (active),
    .sclk      (sclk_w),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SM_IDLE;
    else       state_q <= state_d;
  end

  // Each phase ends on the falling edge that closes its last SCLK period.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    phase_done = 1'b0;
    unique case (state_q)
      SM_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SM_SEND;
        end
      end
      SM_SEND: begin
        phase_done = fall_tick && (bitcnt_q == BCW'(DATA_W - 1));
        if (phase_done) state_d = SM_GAP;
      end
      SM_GAP: begin
        phase_done = fall_tick && (bitcnt_q == BCW'(WAIT_SCLKS - 1));
        if (phase_done) state_d = SM_RECV;
      end
      SM_RECV: begin
        phase_done = fall_tick && (bitcnt_q == BCW'(RES_W - 1));
        if (phase_done) state_d = SM_DONE;
      end
      SM_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SM_SEND;
        end else begin
          state_d = SM_IDLE;
        end
      end
      default: state_d = SM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt_q <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        tx_sh    <= bus.tx_data;
        bitcnt_q <= '0;
      end else if (fall_tick) begin
        bitcnt_q <= phase_done ? '0 : bitcnt_q + 1'b1;
        if (state_q == SM_SEND) tx_sh <= tx_sh << 1;
      end
      if (rise_tick && state_q == SM_RECV) rx_sh <= (rx_sh << 1) | RES_W'(bus.miso);
      if (state_q == SM_RECV && phase_done) result_q <= rx_sh;
    end
  end

  assign active           = (state_q == SM_SEND) || (state_q == SM_GAP) || (state_q == SM_RECV);
  assign bus.busy         = active;
  assign bus.cs           = active ? CS_ACTIVE : ~CS_ACTIVE;
  assign bus.sclk         = sclk_w;
  assign bus.mosi         = (state_q == SM_SEND) ? tx_sh[DATA_W-1] : 1'b0;
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == SM_DONE);

endmodule

// File: tb/tb_spi_mult_master.sv
// Bench for spi_mult_master: a per-transaction timing model checks every pin each
// cycle on two instances (CLK_DIV=2 and CLK_DIV=1); directed literals pin the model.
module tb_spi_mult_master;

  localparam int N = 8 + 16 + 8;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  spi_mult_master_if #(.DATA_W(8), .RES_W(8)) b0 ();
  spi_mult_master_if #(.DATA_W(8), .RES_W(8)) b1 ();

  spi_mult_master #(.DATA_W(8), .RES_W(8), .CLK_DIV(2), .WAIT_SCLKS(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  spi_mult_master #(.DATA_W(8), .RES_W(8), .CLK_DIV(1), .WAIT_SCLKS(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {busy, cs, sclk, mosi, miso} in cycle r after the accept edge,
  // for divider c: r=1..2cN are the N SCLK periods, anything else is quiet.
  function automatic logic [4:0] pins(input int r, input int c, input logic [7:0] frame,
                                      input logic [7:0] reply);
    logic [4:0] v;
    int p, h;
    v = '0;
    if (r >= 1 && r <= 2 * c * N) begin
      p    = (r - 1) / (2 * c);
      h    = (r - 1) % (2 * c);
      v[4] = 1'b1;
      v[3] = 1'b1;
      v[2] = (h >= c);
      if (p < 8)   v[1] = frame[7-p];
      if (p >= 24) v[0] = reply[7-(p-24)];
    end
    return v;
  endfunction

  bit         act0, act1;
  int         acc0, acc1;
  logic [7:0] frm0, frm1, rep0, rep1, res0, res1, reply0, reply1;
  logic [4:0] e0, e1;
  logic       rv0, rv1;

  initial begin
    act0 = 0; acc0 = 0; frm0 = '0; rep0 = '0; res0 = '0;
    forever begin
      @(negedge clk);
      e0 = '0; rv0 = 1'b0;
      if (reset) begin
        act0 = 0; res0 = '0;
      end else begin
        if (act0) begin
          e0  = pins(cyc - acc0, 2, frm0, rep0);
          rv0 = (cyc - acc0 == 4 * N + 1);
          if (rv0) begin res0 = rep0; act0 = 0; end
        end
        if (!act0 && b0.start) begin
          act0 = 1; acc0 = cyc; frm0 = b0.tx_data; rep0 = reply0;
        end
      end
      b0.miso = e0[0];
      check("d0.busy", b0.busy, e0[4]);
      check("d0.cs", b0.cs, e0[3]);
      check("d0.sclk", b0.sclk, e0[2]);
      check("d0.mosi", b0.mosi, e0[1]);
      check("d0.result_valid", b0.result_valid, rv0);
      check("d0.result", b0.result, res0);
    end
  end

  initial begin
    act1 = 0; acc1 = 0; frm1 = '0; rep1 = '0; res1 = '0;
    forever begin
      @(negedge clk);
      e1 = '0; rv1 = 1'b0;
      if (reset) begin
        act1 = 0; res1 = '0;
      end else begin
        if (act1) begin
          e1  = pins(cyc - acc1, 1, frm1, rep1);
          rv1 = (cyc - acc1 == 2 * N + 1);
          if (rv1) begin res1 = rep1; act1 = 0; end
        end
        if (!act1 && b1.start) begin
          act1 = 1; acc1 = cyc; frm1 = b1.tx_data; rep1 = reply1;
        end
      end
      b1.miso = e1[0];
      check("d1.busy", b1.busy, e1[4]);
      check("d1.cs", b1.cs, e1[3]);
      check("d1.sclk", b1.sclk, e1[2]);
      check("d1.mosi", b1.mosi, e1[1]);
      check("d1.result_valid", b1.result_valid, rv1);
      check("d1.result", b1.result, res1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One CLK_DIV=2 transaction with ignored start pulses and a late tx_data change.
  task automatic txn0(input logic [7:0] tx, input logic [7:0] rep,
                      input logic [7:0] rise_exp, input logic [7:0] res_exp);
    b0.tx_data = tx;
    reply0     = rep;
    b0.start   = 1'b1;
    tick();
    for (int r = 1; r <= 130; r++) begin
      b0.start = (r == 10 || r == 60);
      if (r == 1) b0.tx_data = ~tx;
      for (int k = 1; k <= 8; k++)
        if (r == 1 + 2 * (2 * k - 1)) begin
          check("lit.rise_sclk", b0.sclk, 1'b1);
          check("lit.rise_mosi", b0.mosi, rise_exp[8-k]);
        end
      if (r == 128) check("lit.rv_early", b0.result_valid, 1'b0);
      if (r == 129) begin
        check("lit.rv129", b0.result_valid, 1'b1);
        check("lit.result129", b0.result, res_exp);
        check("lit.busy129", b0.busy, 1'b0);
        check("lit.cs129", b0.cs, 1'b0);
      end
      tick();
    end
    b0.start = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reply0 = '0; reply1 = '0;
    b0.start = 1'b0; b0.tx_data = '0;
    b1.start = 1'b0; b1.tx_data = '0;
    reset = 1'b1;
    tick(3);
    check("lit.rst_busy", b0.busy, 1'b0);
    check("lit.rst_cs", b0.cs, 1'b0);
    check("lit.rst_sclk", b0.sclk, 1'b0);
    check("lit.rst_result", b0.result, 8'h00);
    reset = 1'b0;
    tick(2);

    txn0(8'h35, 8'h0F, 8'b0011_0101, 8'h0F);
    tick(3);

    // Abort after the third SCLK rise (relative cycle 11).
    b0.tx_data = 8'h35; reply0 = 8'h0F; b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    tick(11);
    reset = 1'b1;
    #1;
    check("lit.abort_sclk", b0.sclk, 1'b0);
    check("lit.abort_cs", b0.cs, 1'b0);
    check("lit.abort_mosi", b0.mosi, 1'b0);
    check("lit.abort_busy", b0.busy, 1'b0);
    check("lit.abort_result", b0.result, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(2);
    txn0(8'hA2, 8'h5A, 8'b1010_0010, 8'h5A);
    tick(3);

    // start held through DONE: second frame follows with one-cycle cs gap.
    b0.tx_data = 8'h35; reply0 = 8'h0F; b0.start = 1'b1;
    tick();
    for (int r = 1; r <= 260; r++) begin
      if (r == 1) begin reply0 = 8'h30; b0.tx_data = 8'hC3; end
      if (r == 130) b0.start = 1'b0;
      if (r == 128) check("lit.b2b_cs128", b0.cs, 1'b1);
      if (r == 129) begin
        check("lit.b2b_cs129", b0.cs, 1'b0);
        check("lit.b2b_rv1", b0.result_valid, 1'b1);
        check("lit.b2b_res1", b0.result, 8'h0F);
      end
      if (r == 130) check("lit.b2b_cs130", b0.cs, 1'b1);
      if (r == 131) check("lit.b2b_sclk131", b0.sclk, 1'b0);
      if (r == 132) check("lit.b2b_sclk132", b0.sclk, 1'b1);
      if (r == 258) begin
        check("lit.b2b_rv2", b0.result_valid, 1'b1);
        check("lit.b2b_res2", b0.result, 8'h30);
      end
      tick();
    end
    tick(3);

    // CLK_DIV=1 instance with MISO high for the whole reply.
    b1.tx_data = 8'h35; reply1 = 8'hFF; b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    for (int r = 1; r <= 66; r++) begin
      if (r == 1) check("lit.d1_sclk1", b1.sclk, 1'b0);
      if (r == 2) check("lit.d1_sclk2", b1.sclk, 1'b1);
      if (r == 3) check("lit.d1_sclk3", b1.sclk, 1'b0);
      if (r == 4) check("lit.d1_sclk4", b1.sclk, 1'b1);
      if (r == 64) check("lit.d1_rv64", b1.result_valid, 1'b0);
      if (r == 65) begin
        check("lit.d1_rv65", b1.result_valid, 1'b1);
        check("lit.d1_result", b1.result, 8'hFF);
        check("lit.d1_busy65", b1.busy, 1'b0);
      end
      tick();
    end
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
